// File: rtl/data_bus_decoder.sv
// Data-side interconnect: decodes the core's data port onto N_SLAVES
// base/mask windows, tracks one outstanding transaction and reports faults.
module data_bus_decoder #(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned DATA_W   = 32,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE =
        {32'h8000_1000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00},
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       m_req_i,
    input  logic                       m_we_i,
    input  logic [DATA_W/8-1:0]        m_be_i,
    input  logic [31:0]                m_addr_i,
    input  logic [DATA_W-1:0]          m_wdata_i,
    output logic                       m_gnt_o,
    output logic                       m_rvalid_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic                       m_err_o,
    output logic [N_SLAVES-1:0]        s_req_o,
    output logic                       s_we_o,
    output logic [DATA_W/8-1:0]        s_be_o,
    output logic [31:0]                s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    input  logic [N_SLAVES-1:0]        s_gnt_i,
    input  logic [N_SLAVES-1:0]        s_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata_i,
    output logic [31:0]                err_addr_o,
    output logic [15:0]                err_cnt_o
);

    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic                dec_hit;
    logic [SEL_W-1:0]    dec_sel;
    logic                err_evt;

    // Walk from the top index down so the lowest matching window wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        err_evt    = 1'b0;
        s_req_o    = '0;
        m_gnt_o    = 1'b0;
        m_rvalid_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m_req_i) begin
                    if (dec_hit) begin
                        s_req_o[dec_sel] = 1'b1;
                        m_gnt_o          = s_gnt_i[dec_sel];
                        if (s_gnt_i[dec_sel]) begin
                            sel_d   = dec_sel;
                            addr_d  = m_addr_i;
                            cnt_d   = 8'd1;
                            state_d = ST_WAIT;
                        end
                    end else begin
                        m_gnt_o    = 1'b1;
                        rdata_d    = '0;
                        err_d      = 1'b1;
                        err_addr_d = m_addr_i;
                        err_evt    = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Slave data on the timeout cycle itself still wins.
                if (s_rvalid_i[sel_q]) begin
                    rdata_d = s_rdata_i[DATA_W*sel_q +: DATA_W];
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    err_addr_d = addr_q;
                    err_evt    = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                m_rvalid_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // Handshake outputs are combinational, so hold them quiet while in reset.
        if (rst_i) begin
            s_req_o = '0;
            m_gnt_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m_rdata_o  = rdata_q;
    assign m_err_o    = err_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

    assign s_we_o     = m_we_i;
    assign s_be_o     = m_be_i;
    assign s_addr_o   = m_addr_i;
    assign s_wdata_o  = m_wdata_i;

endmodule

// File: tb/tb_data_bus_decoder.sv
// Randomised transaction-level bench for data_bus_decoder: the bench plays the
// master and every slave, and predicts each response from address windows and timing rules.
module tb_data_bus_decoder;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 15;
    // slot0 0x0-0xFF, slot1 0x8000_0000-0x8000_0FFF, slot2 0x2000-0x2FFF, slot3 0x2000-0x20FF
    localparam logic [N*32-1:0] BASE =
        {32'h0000_2000, 32'h0000_2000, 32'h8000_0000, 32'h0000_0000};
    localparam logic [N*32-1:0] MASK =
        {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00};

    logic            clk = 1'b0;
    logic            rst;
    logic            m_req, m_we;
    logic [3:0]      m_be;
    logic [31:0]     m_addr, m_wdata;
    logic            m_gnt, m_rvalid, m_err;
    logic [31:0]     m_rdata;
    logic [N-1:0]    s_req;
    logic            s_we;
    logic [3:0]      s_be;
    logic [31:0]     s_addr, s_wdata;
    logic [N-1:0]    s_gnt, s_rvalid;
    logic [N*DW-1:0] s_rdata;
    logic [31:0]     err_addr;
    logic [15:0]     err_cnt;

    data_bus_decoder #(
        .N_SLAVES(N), .DATA_W(DW), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .err_addr_o(err_addr), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s @cyc %0d: bound expired", name, cyc);
    endtask

    // Reference model: address windows as plain inclusive ranges.
    logic [31:0] win_lo [N] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_2000, 32'h0000_2000};
    logic [31:0] win_hi [N] = '{32'h0000_00FF, 32'h8000_0FFF, 32'h0000_2FFF, 32'h0000_20FF};

    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if (a >= win_lo[i] && a <= win_hi[i]) return i;
        return -1;
    endfunction

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] eaddr;
        logic [15:0] ecnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl_eaddr = '0;
    int          mdl_ecnt  = 0;
    int          last_rv_cyc = -1;

    task automatic expect_resp(input int at, input logic err, input logic [31:0] rd,
                               input logic [31:0] a);
        exp_t e;
        if (err) begin
            mdl_eaddr = a;
            if (mdl_ecnt < 65535) mdl_ecnt++;
        end
        e.cyc   = at;
        e.err   = err;
        e.rdata = rd;
        e.eaddr = mdl_eaddr;
        e.ecnt  = 16'(mdl_ecnt);
        exp_q.push_back(e);
    endtask

    // Single compare process: every cycle out of reset, rvalid must match the model.
    always @(negedge clk) begin : cmp
        logic want;
        if (!rst) begin
            want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            check("rvalid", m_rvalid, want);
            if (m_rvalid) last_rv_cyc = cyc;
            if (want) begin
                check("rdata",    m_rdata,  exp_q[0].rdata);
                check("err",      m_err,    exp_q[0].err);
                check("err_addr", err_addr, exp_q[0].eaddr);
                check("err_cnt",  err_cnt,  exp_q[0].ecnt);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One master transaction with the bench acting as every slave.
    // gdly: cycles the target slave withholds grant; rdly: cycles after accept to rvalid.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input int gdly, input int rdly,
                          input logic [31:0] rd, input logic late, output int acc_c);
        int sel, k, pulse_c, last_c;
        bit got;
        sel    = model_sel(addr);
        m_req  = 1'b1;
        m_we   = we;
        m_be   = be;
        m_addr = addr;
        m_wdata = wdata;
        got    = 1'b0;
        k      = 0;
        acc_c  = -1;
        while (!got && k <= gdly + 8) begin
            s_gnt = '0;
            if (sel >= 0 && k == gdly) s_gnt[sel] = 1'b1;
            s_rvalid = 4'($urandom);
            s_rdata  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("s_req", s_req, (sel >= 0) ? (4'b0001 << sel) : 4'b0000);
            check("m_gnt", m_gnt, (sel < 0) || (k == gdly));
            if (k == 0) begin
                check("pass_addr",  s_addr,  addr);
                check("pass_we",    s_we,    we);
                check("pass_be",    s_be,    be);
                check("pass_wdata", s_wdata, wdata);
            end
            if (m_gnt) begin
                got   = 1'b1;
                acc_c = cyc;
            end
            next_cyc();
            k++;
        end
        m_req    = 1'b0;
        s_gnt    = '0;
        s_rvalid = '0;
        if (!got) begin
            fail_now("grant_wait");
            return;
        end

        pulse_c = -1;
        if (sel < 0) begin
            expect_resp(acc_c + 1, 1'b1, 32'h0, addr);
            last_c = acc_c + 1;
        end else if (rdly <= TO) begin
            expect_resp(acc_c + rdly + 1, 1'b0, rd, addr);
            pulse_c = acc_c + rdly;
            last_c  = acc_c + rdly + 1;
        end else begin
            expect_resp(acc_c + TO + 1, 1'b1, 32'h0, addr);
            if (late) pulse_c = acc_c + rdly;
            last_c = (late && pulse_c > acc_c + TO + 1) ? pulse_c : acc_c + TO + 1;
        end

        // Other slaves chatter on rvalid throughout; only the target's pulse may count.
        for (int c = acc_c + 1; c <= last_c; c++) begin
            s_rvalid = 4'($urandom);
            s_rdata  = {$urandom, $urandom, $urandom, $urandom};
            if (sel >= 0) begin
                s_rvalid[sel] = (c == pulse_c);
                if (c == pulse_c) s_rdata[32*sel +: 32] = rd;
            end
            next_cyc();
        end
        s_rvalid = '0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, r, gd, rdl;
        logic [31:0] a;
        logic [31:0] edge_addr [7] = '{32'h0000_00FF, 32'h0000_0100, 32'h8000_0FFF,
                                       32'h8000_1000, 32'h0000_1FFF, 32'h0000_3000,
                                       32'h0000_20FF};
        rst = 1'b1;
        m_req = 1'b0; m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
        s_gnt = '0; s_rvalid = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid",   m_rvalid, 1'b0);
        check("rst_gnt",      m_gnt,    1'b0);
        check("rst_s_req",    s_req,    4'b0);
        check("rst_rdata",    m_rdata,  32'h0);
        check("rst_err",      m_err,    1'b0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_err_cnt",  err_cnt,  16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        next_cyc();

        // Read 0x10: grant at C, data at C+1, response at C+2.
        do_txn(32'h10, 1'b0, 4'hF, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0, acc);
        check("read_lat",   last_rv_cyc, acc + 2);
        check("read_rdata", m_rdata,     32'hDEAD_BEEF);
        check("read_err",   m_err,       1'b0);

        // Write with three wait states on grant.
        do_txn(32'h8000_0004, 1'b1, 4'b0011, 32'hCAFE_F00D, 3, 2, 32'h0000_0055, 1'b0, acc);
        check("write_err", m_err, 1'b0);

        // Unmapped read.
        do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, 1'b0, acc);
        check("miss_lat",      last_rv_cyc, acc + 1);
        check("miss_rdata",    m_rdata,     32'h0);
        check("miss_err",      m_err,       1'b1);
        check("miss_err_addr", err_addr,    32'h4000_0000);
        check("miss_err_cnt",  err_cnt,     16'd1);

        // Silent slave with a stray pulse at C+20.
        do_txn(32'h8000_0010, 1'b0, 4'hF, 32'h0, 1, 20, 32'h1111_1111, 1'b1, acc);
        check("to_lat",      last_rv_cyc, acc + 16);
        check("to_err_cnt",  err_cnt,     16'd2);
        check("to_err_addr", err_addr,    32'h8000_0010);

        // rvalid on the very cycle the counter reaches TIMEOUT.
        do_txn(32'h8000_0020, 1'b0, 4'hF, 32'h0, 0, TO, 32'h1234_5678, 1'b0, acc);
        check("edge_lat",     last_rv_cyc, acc + 16);
        check("edge_rdata",   m_rdata,     32'h1234_5678);
        check("edge_err",     m_err,       1'b0);
        check("edge_err_cnt", err_cnt,     16'd2);

        // Overlapping windows: only the lower index is requested.
        m_req = 1'b1; m_addr = 32'h0000_2004;
        @(negedge clk);
        check("overlap_req", s_req, 4'b0100);
        next_cyc();
        m_req = 1'b0;
        do_txn(32'h0000_2004, 1'b0, 4'hF, 32'h0, 2, 3, 32'hA5A5_0002, 1'b0, acc);

        // Counter saturation.
        force dut.err_cnt_q = 16'hFFFE;
        next_cyc();
        release dut.err_cnt_q;
        mdl_ecnt = 65534;
        do_txn(32'h9000_0000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, 1'b0, acc);
        do_txn(32'h9000_0004, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, 1'b0, acc);
        check("sat_err_cnt", err_cnt, 16'hFFFF);

        // Reset during WAIT aborts with no response.
        m_req = 1'b1; m_addr = 32'h0000_0010; s_gnt = 4'b0001;
        next_cyc();
        m_req = 1'b0; s_gnt = '0;
        next_cyc();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid",   m_rvalid, 1'b0);
        check("arst_gnt",      m_gnt,    1'b0);
        check("arst_s_req",    s_req,    4'b0);
        check("arst_rdata",    m_rdata,  32'h0);
        check("arst_err",      m_err,    1'b0);
        check("arst_err_addr", err_addr, 32'h0);
        check("arst_err_cnt",  err_cnt,  16'h0);
        exp_q.delete();
        mdl_ecnt  = 0;
        mdl_eaddr = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        s_rvalid = 4'b0001;
        s_rdata[31:0] = 32'hBAD0_BAD0;
        next_cyc();
        s_rvalid = '0;
        repeat (4) next_cyc();

        // Randomised traffic.
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: a = 32'h0000_0000 | 32'($urandom_range(0, 255));
                1: a = 32'h8000_0000 | 32'($urandom_range(0, 4095));
                2: a = 32'h0000_2000 | 32'($urandom_range(0, 4095));
                3: a = $urandom;
                default: a = edge_addr[$urandom_range(0, 6)];
            endcase
            gd  = $urandom_range(0, 3);
            rdl = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 3)
                                              : $urandom_range(1, 6);
            do_txn(a, 1'($urandom), 4'($urandom), $urandom, gd, rdl, $urandom,
                   1'($urandom), acc);
            if ($urandom_range(0, 3) == 0) next_cyc();
        end

        repeat (4) next_cyc();
        if (exp_q.size() != 0) fail_now("pending_responses");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
